// File: rtl/cpu_memory_responder_if.sv
// CPU fetch/load/store bus, boot-stream handshake and load status between the CPU side and the responder.
interface cpu_memory_responder_if #(
    parameter int ADDR_W = 8
);
    logic [31:0]     instr_addr;
    logic [31:0]     instr;
    logic [31:0]     data_addr;
    logic            mem_read_en;
    logic            mem_write_en;
    logic [31:0]     mem_write_data;
    logic [31:0]     mem_read_data;
    logic            load_valid;
    logic            load_ready;
    logic [31:0]     load_data;
    logic            load_last;
    logic            cpu_hold;
    logic [ADDR_W:0] load_count;
    logic            addr_err;

    modport master (
        output instr_addr, data_addr, mem_read_en, mem_write_en, mem_write_data,
        output load_valid, load_data, load_last,
        input  instr, mem_read_data, load_ready, cpu_hold, load_count, addr_err
    );

    modport slave (
        input  instr_addr, data_addr, mem_read_en, mem_write_en, mem_write_data,
        input  load_valid, load_data, load_last,
        output instr, mem_read_data, load_ready, cpu_hold, load_count, addr_err
    );
endinterface

// File: rtl/cpu_memory_responder.sv
// Unified word RAM serving CPU fetch and load/store ports, filled first by a boot-stream loader
// that holds the CPU until the image is in place.
module cpu_memory_responder #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_memory_responder_if.slave bus
);
    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] LAST_BEAT = (ADDR_W + 1)'(DEPTH - 1);

    state_t          state;
    logic            cpu_hold_q;
    logic [ADDR_W:0] load_count_q;
    logic            addr_err_q;
    logic [31:0]     mem [DEPTH];

    logic [ADDR_W-1:0] instr_idx;
    logic [ADDR_W-1:0] data_idx;
    logic              instr_in_range;
    logic              data_in_range;
    logic              data_aligned;
    logic              beat;
    logic              cpu_wr_ok;
    logic              err_set;
    logic              unused_instr_lsbs;

    assign instr_idx      = bus.instr_addr[ADDR_W+1:2];
    assign data_idx       = bus.data_addr[ADDR_W+1:2];
    assign instr_in_range = (bus.instr_addr[31:ADDR_W+2] == '0);
    assign data_in_range  = (bus.data_addr[31:ADDR_W+2] == '0);
    assign data_aligned   = (bus.data_addr[1:0] == 2'b00);

    // Fetch ignores byte offset entirely; only the word index matters.
    assign unused_instr_lsbs = ^bus.instr_addr[1:0];

    // Ready drops the instant reset asserts, without waiting for a clock.
    assign bus.load_ready = cpu_hold_q & rst;
    assign beat           = bus.load_valid & bus.load_ready;

    assign cpu_wr_ok = (state == RUN) & bus.mem_write_en & data_aligned & data_in_range;
    assign err_set   = (state == RUN) &
                       ((bus.mem_write_en & ~(data_aligned & data_in_range)) |
                        (bus.mem_read_en  & ~data_in_range) |
                        ~instr_in_range);

    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.load_count = load_count_q;
    assign bus.addr_err   = addr_err_q;

    assign bus.instr         = instr_in_range ? mem[instr_idx] : 32'h0;
    assign bus.mem_read_data = (bus.mem_read_en & data_in_range) ? mem[data_idx] : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= LOAD;
            cpu_hold_q   <= 1'b1;
            load_count_q <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            if (err_set) begin
                addr_err_q <= 1'b1;
            end
            case (state)
                LOAD: begin
                    if (beat) begin
                        load_count_q <= load_count_q + 1'b1;
                        // A full RAM ends the load even without load_last.
                        if (bus.load_last || (load_count_q == LAST_BEAT)) begin
                            state      <= RUN;
                            cpu_hold_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    // Loader and CPU writes are exclusive by state; RAM content survives reset.
    always_ff @(posedge clk) begin
        if (beat) begin
            mem[load_count_q[ADDR_W-1:0]] <= bus.load_data;
        end else if (cpu_wr_ok) begin
            mem[data_idx] <= bus.mem_write_data;
        end
    end
endmodule

// File: tb/tb_cpu_memory_responder.sv
// Scoreboard bench for cpu_memory_responder: directed stimulus queues expectations, monitors compare at negedge.
module tb_cpu_memory_responder;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    localparam int S_INSTR = 0;
    localparam int S_RDATA = 1;
    localparam int S_HOLD  = 2;
    localparam int S_READY = 3;
    localparam int S_COUNT = 4;
    localparam int S_ERR   = 5;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } chk_t;

    logic clk;
    logic rst;

    chk_t        exp_q[$];
    int          beat_q[$];
    int          errors;
    int          checks;

    cpu_memory_responder_if #(.ADDR_W(ADDR_W)) bus ();

    cpu_memory_responder #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input string name, input int sig, input logic [31:0] value);
        chk_t c;
        c.name = name;
        c.sig  = sig;
        c.exp  = value;
        exp_q.push_back(c);
    endtask

    task automatic expect_beat(input int idx);
        beat_q.push_back(idx);
    endtask

    function automatic logic [31:0] sample(input int sig);
        case (sig)
            S_INSTR: return bus.instr;
            S_RDATA: return bus.mem_read_data;
            S_HOLD:  return {31'b0, bus.cpu_hold};
            S_READY: return {31'b0, bus.load_ready};
            S_COUNT: return 32'(bus.load_count);
            default: return {31'b0, bus.addr_err};
        endcase
    endfunction

    // Beat monitor: a handshake visible at negedge is accepted at the next rising edge.
    always @(negedge clk) begin
        if (bus.load_valid && bus.load_ready) begin
            checks++;
            if (beat_q.size() == 0) begin
                errors++;
                $display("FAIL beat: unexpected accept at load_count=%0d", bus.load_count);
            end else begin
                int idx;
                idx = beat_q.pop_front();
                if (32'(bus.load_count) != idx) begin
                    errors++;
                    $display("FAIL beat_index: got %0d expected %0d", bus.load_count, idx);
                end
            end
        end
    end

    // Output monitor: drains every expectation queued for this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            chk_t c;
            logic [31:0] act;
            c   = exp_q.pop_front();
            act = sample(c.sig);
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.instr_addr     = 32'h0;
        bus.data_addr      = 32'h0;
        bus.mem_read_en    = 1'b0;
        bus.mem_write_en   = 1'b0;
        bus.mem_write_data = 32'h0;
        bus.load_valid     = 1'b0;
        bus.load_data      = 32'h0;
        bus.load_last      = 1'b0;

        step();
        expect_sig("rst_hold",  S_HOLD,  32'd1);
        expect_sig("rst_ready", S_READY, 32'd0);
        expect_sig("rst_count", S_COUNT, 32'd0);
        expect_sig("rst_err",   S_ERR,   32'd0);
        step();

        // Three-word boot with load_valid held high.
        rst = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 32'h20010005;
        expect_beat(0);
        expect_sig("t1_ready0", S_READY, 32'd1);
        expect_sig("t1_hold0",  S_HOLD,  32'd1);
        step();
        bus.load_data = 32'h20020007;
        expect_beat(1);
        expect_sig("t1_ready1", S_READY, 32'd1);
        step();
        bus.load_data = 32'h00221820;
        bus.load_last = 1'b1;
        expect_beat(2);
        expect_sig("t1_hold2", S_HOLD, 32'd1);
        step();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.instr_addr = 32'h4;
        expect_sig("t1_count", S_COUNT, 32'd3);
        expect_sig("t1_hold",  S_HOLD,  32'd0);
        expect_sig("t1_ready", S_READY, 32'd0);
        expect_sig("t1_instr4", S_INSTR, 32'h20020007);
        step();
        bus.instr_addr = 32'h8;
        expect_sig("t1_instr8", S_INSTR, 32'h00221820);
        step();

        // Backpressure reload; a LOAD-state store must be dropped silently.
        rst = 1'b0;
        bus.instr_addr = 32'h0;
        expect_sig("t2_rst_count", S_COUNT, 32'd0);
        expect_sig("t2_rst_hold",  S_HOLD,  32'd1);
        step();
        rst = 1'b1;
        bus.load_valid     = 1'b1;
        bus.load_data      = 32'hA0A00001;
        bus.mem_write_en   = 1'b1;
        bus.data_addr      = 32'h8;
        bus.mem_write_data = 32'h00000BAD;
        expect_beat(0);
        step();
        bus.mem_write_en = 1'b0;
        bus.load_valid   = 1'b0;
        bus.load_data    = 32'hFFFFFFFF;
        bus.load_last    = 1'b1;
        expect_sig("t2_count_gap", S_COUNT, 32'd1);
        expect_sig("t2_instr_load", S_INSTR, 32'hA0A00001);
        step();
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hA0A00002;
        expect_beat(1);
        step();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.instr_addr = 32'h4;
        expect_sig("t2_count", S_COUNT, 32'd2);
        expect_sig("t2_hold",  S_HOLD,  32'd0);
        expect_sig("t2_instr4", S_INSTR, 32'hA0A00002);
        step();
        bus.instr_addr = 32'h8;
        expect_sig("t2_instr8_kept", S_INSTR, 32'h00221820);
        expect_sig("t2_err", S_ERR, 32'd0);
        step();
        bus.instr_addr = 32'h0;

        // RUN traffic: read-before-write, store/load, read enable gating, misaligned reads.
        bus.mem_write_en   = 1'b1;
        bus.mem_read_en    = 1'b1;
        bus.data_addr      = 32'h8;
        bus.mem_write_data = 32'h11112222;
        expect_sig("t3_rbw_old", S_RDATA, 32'h00221820);
        step();
        bus.mem_write_en = 1'b0;
        expect_sig("t3_rbw_new", S_RDATA, 32'h11112222);
        step();
        bus.mem_write_en   = 1'b1;
        bus.mem_read_en    = 1'b0;
        bus.data_addr      = 32'h40;
        bus.mem_write_data = 32'hDEADBEEF;
        expect_sig("t3_rd_off_w", S_RDATA, 32'h0);
        step();
        bus.mem_write_en = 1'b0;
        bus.mem_read_en  = 1'b1;
        expect_sig("t3_load40", S_RDATA, 32'hDEADBEEF);
        step();
        bus.mem_read_en = 1'b0;
        expect_sig("t3_rd_off", S_RDATA, 32'h0);
        step();
        bus.mem_read_en = 1'b1;
        bus.data_addr   = 32'h42;
        bus.instr_addr  = 32'h41;
        expect_sig("t3_rd_mis", S_RDATA, 32'hDEADBEEF);
        expect_sig("t3_if_mis", S_INSTR, 32'hDEADBEEF);
        step();
        bus.mem_read_en = 1'b0;
        bus.instr_addr  = 32'h0;
        expect_sig("t3_err", S_ERR, 32'd0);
        step();

        // Bad stores: misaligned then out of range.
        bus.mem_write_en   = 1'b1;
        bus.data_addr      = 32'h41;
        bus.mem_write_data = 32'h12345678;
        expect_sig("t4_err_before", S_ERR, 32'd0);
        step();
        bus.data_addr      = 32'h400;
        bus.mem_write_data = 32'h55555555;
        expect_sig("t4_err_set", S_ERR, 32'd1);
        step();
        bus.mem_write_en = 1'b0;
        bus.mem_read_en  = 1'b1;
        bus.data_addr    = 32'h40;
        expect_sig("t4_keep40", S_RDATA, 32'hDEADBEEF);
        step();
        bus.data_addr = 32'h0;
        expect_sig("t4_keep0", S_RDATA, 32'hA0A00001);
        step();
        bus.data_addr  = 32'h400;
        bus.instr_addr = 32'h400;
        expect_sig("t4_rd_oor", S_RDATA, 32'h0);
        expect_sig("t4_if_oor", S_INSTR, 32'h0);
        step();
        bus.mem_read_en = 1'b0;
        bus.instr_addr  = 32'h0;
        bus.data_addr   = 32'h0;
        expect_sig("t4_err_sticky", S_ERR, 32'd1);
        step();

        // Full-depth load without load_last.
        rst = 1'b0;
        expect_sig("t5_rst_err", S_ERR, 32'd0);
        step();
        rst = 1'b1;
        bus.load_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.load_data = 32'hC0000000 | 32'(i);
            expect_beat(i);
            step();
        end
        bus.load_data = 32'hEEEEEEEE;
        expect_sig("t5_count", S_COUNT, 32'd256);
        expect_sig("t5_hold",  S_HOLD,  32'd0);
        expect_sig("t5_ready", S_READY, 32'd0);
        expect_sig("t5_instr0", S_INSTR, 32'hC0000000);
        step();
        bus.instr_addr = 32'h3FC;
        expect_sig("t5_instr_top", S_INSTR, 32'hC00000FF);
        expect_sig("t5_count_held", S_COUNT, 32'd256);
        step();
        bus.load_valid = 1'b0;
        bus.instr_addr = 32'h400;
        expect_sig("t5_err_pre", S_ERR, 32'd0);
        step();
        bus.instr_addr = 32'h0;
        expect_sig("t5_err_fetch", S_ERR, 32'd1);
        step();

        // Reset in the middle of a 5-beat load, then a single-word restart.
        rst = 1'b0;
        step();
        rst = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hD0000000;
        expect_beat(0);
        step();
        bus.load_data = 32'hD0000001;
        expect_beat(1);
        step();
        rst = 1'b0;
        bus.load_valid = 1'b0;
        expect_sig("t6_count", S_COUNT, 32'd0);
        expect_sig("t6_hold",  S_HOLD,  32'd1);
        expect_sig("t6_ready", S_READY, 32'd0);
        step();
        rst = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 32'h77777777;
        bus.load_last  = 1'b1;
        expect_beat(0);
        step();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        expect_sig("t6_count1", S_COUNT, 32'd1);
        expect_sig("t6_hold0",  S_HOLD,  32'd0);
        expect_sig("t6_instr0", S_INSTR, 32'h77777777);
        step();
        bus.instr_addr = 32'h4;
        expect_sig("t6_instr4", S_INSTR, 32'hD0000001);
        step();
        bus.instr_addr = 32'h8;
        expect_sig("t6_instr8", S_INSTR, 32'hC0000002);
        step();
        step();

        checks++;
        if (beat_q.size() != 0) begin
            errors++;
            $display("FAIL beats_left: got %0d pending expected 0", beat_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
